// File: rtl/core_pkg.sv
// core_pkg: shared core types for the multiply unit (ops, FSM states, iteration count)
package core_pkg;
  typedef enum logic [2:0] {
    MUL_OP_MUL    = 3'd0,
    MUL_OP_MULH   = 3'd1,
    MUL_OP_MULHSU = 3'd2,
    MUL_OP_MULHU  = 3'd3
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_e;

  localparam int MUL_ITER_CYCLES = 32;

  function automatic logic is_mul_op(input mul_op_e op);
    return (op == MUL_OP_MUL) || (op == MUL_OP_MULH) ||
           (op == MUL_OP_MULHSU) || (op == MUL_OP_MULHU);
  endfunction
endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU, valid/ready responder
// Ports:
//   clk_i, rst_ni (async active-low)
//   a_i, b_i, mul_op_i, tag_i, in_valid_i -> in_ready_o : request side
//   flush_i : abort any in-flight or held operation
//   result_o, tag_o, out_valid_o <- out_ready_i : response side
//   busy_o : operation in flight or result held
module seq_multiplier
  import core_pkg::*;
#(
  parameter int TAG_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      a_i,
  input  logic [31:0]      b_i,
  input  mul_op_e          mul_op_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             flush_i,
  output logic [31:0]      result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o
);
  localparam logic [4:0] LAST_COUNT = 5'(MUL_ITER_CYCLES - 1);

  mul_state_e       r_state;
  logic [63:0]      r_acc;
  logic [63:0]      r_mplier;
  logic [31:0]      r_mcand;
  logic [4:0]       r_count;
  logic             r_sign;
  mul_op_e          r_op;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_result;

  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [63:0] w_acc_fixed;
  logic [31:0] w_sel;

  // Magnitudes of 0x80000000 come out as 0x80000000 (2^31), which is exactly right unsigned.
  always_comb begin
    w_a_neg     = ((mul_op_i == MUL_OP_MULH) || (mul_op_i == MUL_OP_MULHSU)) && a_i[31];
    w_b_neg     = (mul_op_i == MUL_OP_MULH) && b_i[31];
    w_a_mag     = w_a_neg ? (~a_i + 32'd1) : a_i;
    w_b_mag     = w_b_neg ? (~b_i + 32'd1) : b_i;
    w_acc_fixed = r_sign ? (~r_acc + 64'd1) : r_acc;
    w_sel       = !is_mul_op(r_op)    ? 32'd0 :
                  (r_op == MUL_OP_MUL) ? w_acc_fixed[31:0] : w_acc_fixed[63:32];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_acc    <= 64'd0;
      r_mplier <= 64'd0;
      r_mcand  <= 32'd0;
      r_count  <= 5'd0;
      r_sign   <= 1'b0;
      r_op     <= MUL_OP_MUL;
      r_tag    <= '0;
      r_result <= 32'd0;
    end else if (flush_i) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: if (in_valid_i) begin
          r_mcand  <= w_a_mag;
          r_mplier <= {32'd0, w_b_mag};
          r_sign   <= w_a_neg ^ w_b_neg;
          r_op     <= mul_op_i;
          r_tag    <= tag_i;
          r_acc    <= 64'd0;
          r_count  <= 5'd0;
          r_state  <= CALC;
        end
        CALC: begin
          if (r_mcand[r_count]) r_acc <= r_acc + r_mplier;
          r_mplier <= r_mplier << 1;
          r_count  <= r_count + 5'd1;
          if (r_count == LAST_COUNT) r_state <= FIX;
        end
        FIX: begin
          r_result <= w_sel;
          r_state  <= DONE;
        end
        DONE: if (out_ready_i) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (r_state == IDLE);
  assign busy_o      = (r_state != IDLE);
  assign out_valid_o = (r_state == DONE);
  assign result_o    = r_result;
  assign tag_o       = r_tag;
endmodule
